// File: rtl/apb_bridge_pkg.sv
// Shared types and address map for the AXI2APB bridge stages.
// Used by the burst manager, decoder and APB transfer engine.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_SLV1 = 2'b01,
    SEL_SLV2 = 2'b10
  } slv_sel_e;

  localparam logic [31:0] SLV1_START = 32'h0001_F000;
  localparam logic [31:0] SLV1_END   = 32'h0001_FFFF;
  localparam logic [31:0] SLV2_START = 32'h0002_F000;
  localparam logic [31:0] SLV2_END   = 32'h0002_FFFF;

endpackage

// File: rtl/apb_xfer_engine_if.sv
// Beat request/response and APB bus bundle of the transfer engine.
// master = engine side, slave = requester plus APB slaves.
interface apb_xfer_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [STRB_WIDTH-1:0] req_strb_i;

  logic                  transfer_done_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;

  logic [1:0]            psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [STRB_WIDTH-1:0] pstrb_o;

  logic [DATA_WIDTH-1:0] prdata1_i;
  logic [DATA_WIDTH-1:0] prdata2_i;
  logic                  pready1_i;
  logic                  pready2_i;
  logic                  pslverr1_i;
  logic                  pslverr2_i;

  modport master (
    input  req_valid_i, req_write_i,
    input  req_addr_i, req_wdata_i,
    input  req_strb_i,
    output req_ready_o,
    output transfer_done_o,
    output rsp_rdata_o, rsp_err_o,
    output psel_o, penable_o, pwrite_o,
    output paddr_o, pwdata_o, pstrb_o,
    input  prdata1_i, prdata2_i,
    input  pready1_i, pready2_i,
    input  pslverr1_i, pslverr2_i
  );

  modport slave (
    output req_valid_i, req_write_i,
    output req_addr_i, req_wdata_i,
    output req_strb_i,
    input  req_ready_o,
    input  transfer_done_o,
    input  rsp_rdata_o, rsp_err_o,
    input  psel_o, penable_o, pwrite_o,
    input  paddr_o, pwdata_o, pstrb_o,
    output prdata1_i, prdata2_i,
    output pready1_i, pready2_i,
    output pslverr1_i, pslverr2_i
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational APB slave window decoder: addr -> hit + one-hot psel.
// Shared by several bridge stages.
module apb_addr_decoder
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [1:0]            psel
);

  localparam logic [ADDR_WIDTH-1:0] S1_LO =
    ADDR_WIDTH'(SLV1_START);
  localparam logic [ADDR_WIDTH-1:0] S1_HI =
    ADDR_WIDTH'(SLV1_END);
  localparam logic [ADDR_WIDTH-1:0] S2_LO =
    ADDR_WIDTH'(SLV2_START);
  localparam logic [ADDR_WIDTH-1:0] S2_HI =
    ADDR_WIDTH'(SLV2_END);

  slv_sel_e sel;
  logic     in1;
  logic     in2;

  assign in1 = (addr >= S1_LO) && (addr <= S1_HI);
  assign in2 = (addr >= S2_LO) && (addr <= S2_HI);

  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      in1:     sel = SEL_SLV1;
      in2:     sel = SEL_SLV2;
      default: sel = SEL_NONE;
    endcase
  end

  assign psel = sel;
  assign hit  = (sel != SEL_NONE);

endmodule

// File: rtl/apb_xfer_engine.sv
// APB master stage of the AXI2APB bridge: one beat per
// SETUP/ACCESS transfer, bounded PREADY wait, 1-cycle done pulse.
module apb_xfer_engine
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  apb_xfer_engine_if.master   bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYCLES);

  apb_state_e state_q;
  apb_state_e state_d;

  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [1:0]            sel_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  dec_hit;
  logic [1:0]            dec_psel;

  logic                  cap;
  logic                  rsp_ld;
  logic                  rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  logic                  s_ready;
  logic                  s_err;
  logic [DATA_WIDTH-1:0] s_rdata;

  apb_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dec (
    .addr (bus.req_addr_i),
    .hit  (dec_hit),
    .psel (dec_psel)
  );

  // Only the slave latched for this beat is listened to.
  always_comb begin
    s_ready = 1'b0;
    s_err   = 1'b0;
    s_rdata = '0;
    unique case (1'b1)
      sel_q[0]: begin
        s_ready = bus.pready1_i;
        s_err   = bus.pslverr1_i;
        s_rdata = bus.prdata1_i;
      end
      sel_q[1]: begin
        s_ready = bus.pready2_i;
        s_err   = bus.pslverr2_i;
        s_rdata = bus.prdata2_i;
      end
      default: ;
    endcase
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap         = 1'b0;
    rsp_ld      = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          cap = 1'b1;
          if (dec_hit) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
          end else begin
            state_d   = ST_RESP;
            rsp_ld    = 1'b1;
            rsp_err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (s_ready) begin
          state_d   = ST_RESP;
          rsp_ld    = 1'b1;
          rsp_err_d = s_err;
          if (!wr_q && !s_err)
            rsp_rdata_d = s_rdata;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_d   = ST_RESP;
            rsp_ld    = 1'b1;
            rsp_err_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        wr_q    <= bus.req_write_i;
        addr_q  <= bus.req_addr_i;
        wdata_q <= bus.req_wdata_i;
        strb_q  <= bus.req_write_i ?
                   bus.req_strb_i : '0;
        sel_q   <= dec_psel;
      end
      if (rsp_ld) begin
        rdata_q <= rsp_rdata_d;
        err_q   <= rsp_err_d;
      end
    end
  end

  // Bus strobes decode straight off state so reset drops them at once.
  assign bus.req_ready_o     = (state_q == ST_IDLE);
  assign bus.transfer_done_o = (state_q == ST_RESP);
  assign bus.penable_o       = (state_q == ST_ACCESS);
  assign bus.psel_o          =
    ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ?
    sel_q : 2'b00;

  assign bus.pwrite_o    = wr_q;
  assign bus.paddr_o     = addr_q;
  assign bus.pwdata_o    = wdata_q;
  assign bus.pstrb_o     = strb_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;

endmodule

// File: tb/tb_apb_xfer_engine.sv
// Scoreboard bench for apb_xfer_engine: per-scenario tasks,
// expected responses queued at request time and popped on done.
module tb_apb_xfer_engine;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t e;
  int   cyc;
  int   n_en;
  bit   seen;

  apb_xfer_engine_if #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) bus ();

  apb_xfer_engine #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_slaves();
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_strb_i  = '0;
    bus.prdata1_i   = '0;
    bus.prdata2_i   = '0;
    bus.pready1_i   = 1'b0;
    bus.pready2_i   = 1'b0;
    bus.pslverr1_i  = 1'b0;
    bus.pslverr2_i  = 1'b0;
  endtask

  // Called at a sample point with the engine idle; returns at
  // the sample point of cycle 1 (after the handshake edge).
  task automatic drive_req(input bit w,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = w;
    bus.req_addr_i  = a;
    bus.req_wdata_i = d;
    bus.req_strb_i  = s;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  // Bounded wait for done; cyc is the cycle index of the pulse.
  task automatic wait_done(output int c, output int en,
                           output bit ok);
    c  = 1;
    en = 0;
    while (!bus.transfer_done_o && c < 64) begin
      if (bus.penable_o) en++;
      @(posedge clk); #1;
      c++;
    end
    ok = bus.transfer_done_o;
  endtask

  task automatic test_reset();
    idle_slaves();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.req_ready_o, bus.psel_o, bus.penable_o,
         bus.transfer_done_o, bus.rsp_err_o} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 100000",
        {bus.req_ready_o, bus.psel_o, bus.penable_o,
         bus.transfer_done_o, bus.rsp_err_o});
    end
    checks++;
    if ({bus.paddr_o, bus.pwdata_o, bus.rsp_rdata_o,
         bus.pstrb_o, bus.pwrite_o} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h exp 0",
        bus.paddr_o, bus.pwdata_o, bus.rsp_rdata_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_zero_wait();
    idle_slaves();
    bus.pready1_i = 1'b1;
    sb.push_back('{err: 1'b0, rdata: 32'h0});
    drive_req(1'b1, 32'h0001_F004, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if ({bus.psel_o, bus.penable_o, bus.req_ready_o}
        !== 4'b0100) begin
      errors++;
      $display("FAIL wr_setup got psel=%b en=%b rdy=%b exp 01/0/0",
        bus.psel_o, bus.penable_o, bus.req_ready_o);
    end
    checks++;
    if ({bus.paddr_o, bus.pwdata_o, bus.pstrb_o, bus.pwrite_o}
        !== {32'h0001_F004, 32'hDEAD_BEEF, 4'hF, 1'b1}) begin
      errors++;
      $display("FAIL wr_bus got %h %h %h %b exp 0001f004 deadbeef f 1",
        bus.paddr_o, bus.pwdata_o, bus.pstrb_o, bus.pwrite_o);
    end
    wait_done(cyc, n_en, seen);
    checks++;
    if (!seen || cyc != 3 || n_en != 1) begin
      errors++;
      $display("FAIL wr_latency got done=%0b c%0d en=%0d exp 1 c3 1",
        seen, cyc, n_en);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL wr_sb got empty exp entry");
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_err_o, bus.rsp_rdata_o} !== e) begin
        errors++;
        $display("FAIL wr_rsp got %b/%h exp %b/%h",
          bus.rsp_err_o, bus.rsp_rdata_o, e.err, e.rdata);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_wait();
    idle_slaves();
    bus.prdata2_i = 32'h1234_5678;
    bus.pready1_i = 1'b1;
    bus.pslverr1_i = 1'b1;
    sb.push_back('{err: 1'b0, rdata: 32'h1234_5678});
    drive_req(1'b0, 32'h0002_F010, 32'hAAAA_5555, 4'hF);
    checks++;
    if ({bus.psel_o, bus.pstrb_o, bus.pwrite_o} !== 7'b10_0000_0) begin
      errors++;
      $display("FAIL rd_setup got psel=%b strb=%h wr=%b exp 10/0/0",
        bus.psel_o, bus.pstrb_o, bus.pwrite_o);
    end
    cyc  = 1;
    n_en = 0;
    while (!bus.transfer_done_o && cyc < 64) begin
      if (bus.penable_o) begin
        n_en++;
        if (n_en == 4) bus.pready2_i = 1'b1;
        if (bus.psel_o !== 2'b10 ||
            bus.paddr_o !== 32'h0002_F010) begin
          checks++;
          errors++;
          $display("FAIL rd_hold got psel=%b addr=%h exp 10/0002f010",
            bus.psel_o, bus.paddr_o);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (!bus.transfer_done_o || cyc != 6 || n_en != 4) begin
      errors++;
      $display("FAIL rd_wait got done=%b c%0d en=%0d exp 1 c6 4",
        bus.transfer_done_o, cyc, n_en);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL rd_sb got empty exp entry");
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_err_o, bus.rsp_rdata_o} !== e) begin
        errors++;
        $display("FAIL rd_rsp got %b/%h exp %b/%h",
          bus.rsp_err_o, bus.rsp_rdata_o, e.err, e.rdata);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_decode_miss();
    idle_slaves();
    bus.pready1_i = 1'b1;
    bus.pready2_i = 1'b1;
    bus.prdata1_i = 32'h1111_1111;
    bus.prdata2_i = 32'h2222_2222;
    sb.push_back('{err: 1'b1, rdata: 32'h0});
    drive_req(1'b0, 32'h0003_0000, 32'h0, 4'h0);
    checks++;
    if ({bus.transfer_done_o, bus.psel_o, bus.penable_o,
         bus.req_ready_o} !== 5'b10000) begin
      errors++;
      $display("FAIL miss_ctl got done=%b psel=%b en=%b rdy=%b exp 1/00/0/0",
        bus.transfer_done_o, bus.psel_o, bus.penable_o,
        bus.req_ready_o);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL miss_sb got empty exp entry");
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_err_o, bus.rsp_rdata_o} !== e) begin
        errors++;
        $display("FAIL miss_rsp got %b/%h exp %b/%h",
          bus.rsp_err_o, bus.rsp_rdata_o, e.err, e.rdata);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.req_ready_o, bus.transfer_done_o} !== 2'b10) begin
      errors++;
      $display("FAIL miss_idle got rdy=%b done=%b exp 1/0",
        bus.req_ready_o, bus.transfer_done_o);
    end
  endtask

  task automatic test_timeout();
    idle_slaves();
    bus.pready2_i = 1'b1;
    sb.push_back('{err: 1'b1, rdata: 32'h0});
    drive_req(1'b1, 32'h0001_F000, 32'h0BAD_F00D, 4'h3);
    wait_done(cyc, n_en, seen);
    checks++;
    if (!seen || n_en != 16 || cyc != 18) begin
      errors++;
      $display("FAIL to_len got done=%0b en=%0d c%0d exp 1 16 c18",
        seen, n_en, cyc);
    end
    checks++;
    if ({bus.psel_o, bus.penable_o} !== 3'b000) begin
      errors++;
      $display("FAIL to_drop got psel=%b en=%b exp 00/0",
        bus.psel_o, bus.penable_o);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL to_sb got empty exp entry");
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_err_o, bus.rsp_rdata_o} !== e) begin
        errors++;
        $display("FAIL to_rsp got %b/%h exp %b/%h",
          bus.rsp_err_o, bus.rsp_rdata_o, e.err, e.rdata);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_slverr();
    idle_slaves();
    bus.pready1_i  = 1'b1;
    bus.pslverr1_i = 1'b1;
    bus.prdata1_i  = 32'hFFFF_FFFF;
    sb.push_back('{err: 1'b1, rdata: 32'h0});
    drive_req(1'b0, 32'h0001_F008, 32'h0, 4'hF);
    wait_done(cyc, n_en, seen);
    checks++;
    if (!seen || cyc != 3) begin
      errors++;
      $display("FAIL se_lat got done=%0b c%0d exp 1 c3", seen, cyc);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL se_sb got empty exp entry");
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_err_o, bus.rsp_rdata_o} !== e) begin
        errors++;
        $display("FAIL se_rsp got %b/%h exp %b/%h",
          bus.rsp_err_o, bus.rsp_rdata_o, e.err, e.rdata);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    idle_slaves();
    bus.pready1_i = 1'b1;
    bus.pready2_i = 1'b1;
    bus.prdata1_i = 32'h5A5A_0F0F;
    sb.push_back('{err: 1'b0, rdata: 32'h0});
    sb.push_back('{err: 1'b0, rdata: 32'h5A5A_0F0F});
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b1;
    bus.req_addr_i  = 32'h0002_F004;
    bus.req_wdata_i = 32'h0000_00C3;
    bus.req_strb_i  = 4'h1;
    @(posedge clk); #1;
    // valid stays high with a new beat while the engine is busy
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = 32'h0001_F010;
    checks++;
    if ({bus.psel_o, bus.paddr_o, bus.pstrb_o}
        !== {2'b10, 32'h0002_F004, 4'h1}) begin
      errors++;
      $display("FAIL b2b_first got psel=%b addr=%h strb=%h exp 10/0002f004/1",
        bus.psel_o, bus.paddr_o, bus.pstrb_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.paddr_o !== 32'h0002_F004 || bus.req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold got addr=%h rdy=%b exp 0002f004/0",
        bus.paddr_o, bus.req_ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if (sb.size() == 0 || bus.transfer_done_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done1 got done=%b sb=%0d exp 1/2",
        bus.transfer_done_o, sb.size());
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_err_o, bus.rsp_rdata_o} !== e) begin
        errors++;
        $display("FAIL b2b_rsp1 got %b/%h exp %b/%h",
          bus.rsp_err_o, bus.rsp_rdata_o, e.err, e.rdata);
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    checks++;
    if ({bus.psel_o, bus.paddr_o, bus.pwrite_o}
        !== {2'b01, 32'h0001_F010, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second got psel=%b addr=%h wr=%b exp 01/0001f010/0",
        bus.psel_o, bus.paddr_o, bus.pwrite_o);
    end
    wait_done(cyc, n_en, seen);
    checks++;
    if (!seen || cyc != 3 || sb.size() == 0) begin
      errors++;
      $display("FAIL b2b_done2 got done=%0b c%0d sb=%0d exp 1 c3 1",
        seen, cyc, sb.size());
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_err_o, bus.rsp_rdata_o} !== e) begin
        errors++;
        $display("FAIL b2b_rsp2 got %b/%h exp %b/%h",
          bus.rsp_err_o, bus.rsp_rdata_o, e.err, e.rdata);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    idle_slaves();
    drive_req(1'b1, 32'h0001_F00C, 32'h7777_7777, 4'hF);
    @(posedge clk); #1;
    checks++;
    if (bus.penable_o !== 1'b1) begin
      errors++;
      $display("FAIL ab_access got en=%b exp 1", bus.penable_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.psel_o, bus.penable_o, bus.transfer_done_o} !== 4'b0) begin
      errors++;
      $display("FAIL ab_drop got psel=%b en=%b done=%b exp 00/0/0",
        bus.psel_o, bus.penable_o, bus.transfer_done_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.transfer_done_o !== 1'b0) begin
        errors++;
        $display("FAIL ab_nodone got done=%b exp 0 at %0d",
          bus.transfer_done_o, i);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready_o !== 1'b1 || bus.transfer_done_o !== 1'b0) begin
      errors++;
      $display("FAIL ab_ready got rdy=%b done=%b exp 1/0",
        bus.req_ready_o, bus.transfer_done_o);
    end
    bus.pready2_i = 1'b1;
    bus.prdata2_i = 32'hCAFE_0001;
    sb.push_back('{err: 1'b0, rdata: 32'hCAFE_0001});
    drive_req(1'b0, 32'h0002_F000, 32'h0, 4'hF);
    wait_done(cyc, n_en, seen);
    checks++;
    if (!seen || cyc != 3 || sb.size() == 0) begin
      errors++;
      $display("FAIL ab_beat got done=%0b c%0d sb=%0d exp 1 c3 1",
        seen, cyc, sb.size());
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_err_o, bus.rsp_rdata_o} !== e) begin
        errors++;
        $display("FAIL ab_rsp got %b/%h exp %b/%h",
          bus.rsp_err_o, bus.rsp_rdata_o, e.err, e.rdata);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_slaves();
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_decode_miss();
    test_timeout();
    test_slverr();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
